instr_encoder: RTL and testbench
================================

# instr_encoder

Program-loading block that produces machine code for the instruction-decoder path, working in the opposite direction to that decoder. It accepts one symbolic instruction per valid/ready handshake (operation select, condition, registers, immediates) and encodes it into a 32-bit ARM word. It then writes that word into instruction memory at consecutive word addresses from BASE. It sits between the test/boot host and the instruction memory write port. It covers exactly the instruction subset the processor decodes: ADD, SUB, AND, ORR, CMP, TEQ, LSL, LDR, STR and B.

## Interface
- BASE, 32'h0000_0000: byte address of the first word written.
- DEPTH, 64: maximum number of words written before the block reports full. Must be ≥1 and ≤ 2^ADDR_W.
- ADDR_W, 6: width of the word index; `count` is ADDR_W+1 bits wide.

Ports:
- clk  in  1  the single clock. All state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous pointer/error clear.
- in_valid  in  1  request valid.
- in_ready  out  1  block can accept a request.
- in_op  in  4  operation select: 0 ADD, 1 SUB, 2 AND, 3 ORR, 4 CMP, 5 TEQ, 6 LSL, 7 LDR, 8 STR, 9 B. Values 10–15 are illegal.
- in_cond  in  4  condition field. 4'b1111 is illegal.
- in_s  in  1  S bit for ADD/SUB/AND/ORR/LSL.
- in_imm  in  1  for ADD..TEQ: 1 means immediate Src2, 0 means register Src2.
- in_rd, in_rn, in_rm  in  4 each  register fields.
- in_imm12  in  12  one of: {rot4,imm8} for DP immediates; the offset for LDR/STR; shamt in [4:0] for LSL.
- in_imm24  in  24  branch offset.
- imem_we  out  1  instruction memory write strobe.
- imem_addr  out  32  byte address of the write.
- imem_wd  out  32  encoded word.
- count  out  ADDR_W+1  number of words written.
- full  out  1  count == DEPTH.
- err  out  1  sticky: an illegal request was seen.
- busy  out  1  state ≠ IDLE.

## Operation
- FSM states: IDLE, ENC, WR.
  - IDLE → ENC on handshake (in_valid & in_ready). All in_* fields are latched on that edge.
  - ENC → WR for a legal request.
  - ENC → IDLE for an illegal request; err is set and nothing is written.
  - WR → IDLE unconditionally; count increments.
- in_ready = (state==IDLE) & !full & !clear.
- Encoding layout: {cond[31:28], op[27:26], funct[25:20], Rn[19:16], Rd[15:12], Src2[11:0]}.
- DP operations (ADD..TEQ): op=00; funct={I,cmd,S}. cmd values: ADD 0100, SUB 0010, AND 0000, ORR 1100, CMP 1010, TEQ 1001.
  - I=in_imm. Src2 = in_imm12 when I=1, otherwise {8'b0,in_rm}.
  - CMP/TEQ: S is forced to 1 and Rd is forced to 0.
- LSL: op=00, I=0, cmd=1101, S=in_s, Rn=0. Src2={in_imm12[4:0], 2'b00, 1'b0, in_rm}.
- LDR/STR: op=01, funct={0,1,1,0,0,L}. L=1 for LDR, 0 for STR. Src2=in_imm12.
- B: word = {cond, 2'b10, 2'b10, in_imm24}.
- Address: imem_addr = BASE + {count, 2'b00}, computed modulo 2^32.
- clear has priority over every other input. From any state it sets count=0, err=0 and state=IDLE. A write in flight is aborted, so imem_we=0 in that cycle. No request is accepted in the clear cycle.
- Reset values: state=IDLE, count=0, err=0, imem_we=0, imem_addr=BASE, imem_wd=0, in_ready=1, full=0, busy=0.

## Timing
- Handshake accepted at edge T. The encoded word is registered at edge T+1 (ENC). imem_we is high for exactly one cycle between edges T+1 and T+2. imem_addr and imem_wd are stable while imem_we is high.
- count increments at edge T+2, and in_ready returns high in the same cycle. Throughput is one instruction per 3 cycles.
- Illegal request: err rises after edge T+1 and in_ready returns after edge T+1. count is unchanged.
- Full: after the DEPTH-th write, full=1 and in_ready=0 until clear or reset. There is no wrap-around.
- in_* fields are don't-care outside the handshake cycle.
- An asynchronous reset mid-operation drops the pending write immediately.

## Test plan
- ADD, cond E, Rd2, Rn0, imm 5, S=0 → imem_wd=0xE2802005 at imem_addr=BASE. Then SUB S=1, Rd3, Rn1, Rm2 → 0xE0513002 at BASE+4. count=2.
- CMP Rn1 #0 with in_rd=7 → 0xE3510000 (Rd forced 0). TEQ Rn1, Rm2 → 0xE1310002. LSL Rd5, Rm6, shamt 3 → 0xE1A05186.
- LDR Rd4 [Rn0,#8] → 0xE5904008. STR same fields → 0xE5804008. B cond E, imm24=2 → 0xEA000002.
- in_op=12, then a request with cond=F → no imem_we, err=1, count unchanged. Next legal ADD is written at the unchanged address.
- DEPTH=4: issue 5 requests back-to-back → 4 writes. full=1 and in_ready=0 on the 5th. clear → count=0, full=0, err=0, next write at BASE.
- Assert reset during ENC, and separately pulse clear during WR → imem_we stays 0, count=0, state IDLE next cycle.

Source files
------------

// File: rtl/instr_encoder.sv
// Symbolic instruction to 32-bit ARM word encoder for the supported subset.
// Accepts one request per handshake and writes the word to consecutive instruction-memory addresses.
module instr_encoder #(
  parameter logic [31:0] BASE   = 32'h0000_0000,
  parameter int          DEPTH  = 64,
  parameter int          ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [3:0]        in_cond,
  input  logic              in_s,
  input  logic              in_imm,
  input  logic [3:0]        in_rd,
  input  logic [3:0]        in_rn,
  input  logic [3:0]        in_rm,
  input  logic [11:0]       in_imm12,
  input  logic [23:0]       in_imm24,
  output logic              imem_we,
  output logic [31:0]       imem_addr,
  output logic [31:0]       imem_wd,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              err,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ENC, WR} state_t;

  localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  state_t          state_reg, state_next;
  logic [ADDR_W:0] count_reg, count_next;
  logic            err_reg, err_next;
  logic            we_reg, we_next;
  logic [31:0]     addr_reg, addr_next;
  logic [31:0]     wd_reg, wd_next;

  logic [3:0]      op_reg, cond_reg, rd_reg, rn_reg, rm_reg;
  logic            s_reg, imm_reg;
  logic [11:0]     imm12_reg;
  logic [23:0]     imm24_reg;

  logic            full_w;
  logic            load;
  logic [9:0]      op_hot;
  logic            is_dp, is_cmp, is_lsl, is_mem, is_b, legal;
  logic [3:0]      cmd;
  logic [31:0]     enc_word;

  assign full_w   = (count_reg == DEPTH_CNT);
  assign in_ready = (state_reg == IDLE) & ~full_w & ~clear;
  assign load     = in_valid & in_ready;

  // Request fields are captured only on the accepting edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_reg    <= 4'h0;
      cond_reg  <= 4'h0;
      s_reg     <= 1'b0;
      imm_reg   <= 1'b0;
      rd_reg    <= 4'h0;
      rn_reg    <= 4'h0;
      rm_reg    <= 4'h0;
      imm12_reg <= 12'h000;
      imm24_reg <= 24'h000000;
    end else if (load) begin
      op_reg    <= in_op;
      cond_reg  <= in_cond;
      s_reg     <= in_s;
      imm_reg   <= in_imm;
      rd_reg    <= in_rd;
      rn_reg    <= in_rn;
      rm_reg    <= in_rm;
      imm12_reg <= in_imm12;
      imm24_reg <= in_imm24;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 10; gi++) begin : g_op_dec
      assign op_hot[gi] = (op_reg == 4'(gi));
    end
  endgenerate

  assign is_dp  = |op_hot[5:0];
  assign is_cmp = op_hot[4] | op_hot[5];
  assign is_lsl = op_hot[6];
  assign is_mem = op_hot[7] | op_hot[8];
  assign is_b   = op_hot[9];
  // Ops 10-15 leave op_hot empty; cond 4'b1111 is reserved.
  assign legal  = (|op_hot) & (cond_reg != 4'hF);

  always_comb begin
    cmd = 4'b0000;
    case (op_reg)
      4'd0:    cmd = 4'b0100;
      4'd1:    cmd = 4'b0010;
      4'd2:    cmd = 4'b0000;
      4'd3:    cmd = 4'b1100;
      4'd4:    cmd = 4'b1010;
      4'd5:    cmd = 4'b1001;
      4'd6:    cmd = 4'b1101;
      default: cmd = 4'b0000;
    endcase
  end

  always_comb begin
    enc_word = 32'h0000_0000;
    if (is_dp) begin
      enc_word = {cond_reg, 2'b00, imm_reg, cmd, (is_cmp ? 1'b1 : s_reg),
                  rn_reg, (is_cmp ? 4'h0 : rd_reg),
                  (imm_reg ? imm12_reg : {8'h00, rm_reg})};
    end else if (is_lsl) begin
      enc_word = {cond_reg, 2'b00, 1'b0, cmd, s_reg, 4'h0, rd_reg,
                  imm12_reg[4:0], 2'b00, 1'b0, rm_reg};
    end else if (is_mem) begin
      enc_word = {cond_reg, 2'b01, 5'b01100, op_hot[7], rn_reg, rd_reg, imm12_reg};
    end else if (is_b) begin
      enc_word = {cond_reg, 2'b10, 2'b10, imm24_reg};
    end
  end

  always_comb begin
    state_next = state_reg;
    count_next = count_reg;
    err_next   = err_reg;
    we_next    = 1'b0;
    wd_next    = wd_reg;
    if (clear) begin
      state_next = IDLE;
      count_next = '0;
      err_next   = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (load) state_next = ENC;
        end
        ENC: begin
          if (legal) begin
            state_next = WR;
            we_next    = 1'b1;
            wd_next    = enc_word;
          end else begin
            state_next = IDLE;
            err_next   = 1'b1;
          end
        end
        WR: begin
          state_next = IDLE;
          count_next = count_reg + CNT_ONE;
        end
        default: state_next = IDLE;
      endcase
    end
    addr_next = BASE + 32'({count_next, 2'b00});
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      count_reg <= '0;
      err_reg   <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= BASE;
      wd_reg    <= 32'h0000_0000;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      err_reg   <= err_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wd_reg    <= wd_next;
    end
  end

  // clear kills an in-flight write strobe in the same cycle it is asserted.
  assign imem_we   = we_reg & ~clear;
  assign imem_addr = addr_reg;
  assign imem_wd   = wd_reg;
  assign count     = count_reg;
  assign full      = full_w;
  assign err       = err_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder with BASE=0x100, DEPTH=4.
// Each task drives one scenario and compares against hand-computed words and addresses.
module tb_instr_encoder;

  localparam logic [31:0] BASE = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        reset, clear, in_valid, in_ready;
  logic [3:0]  in_op, in_cond, in_rd, in_rn, in_rm;
  logic        in_s, in_imm;
  logic [11:0] in_imm12;
  logic [23:0] in_imm24;
  logic        imem_we;
  logic [31:0] imem_addr, imem_wd;
  logic [3:0]  count;
  logic        full, err, busy;

  int checks = 0;
  int errors = 0;

  logic        obs_we, obs_we_after, obs_err, obs_ready_mid, obs_ready;
  logic [31:0] obs_addr, obs_wd;
  logic [3:0]  obs_count;

  instr_encoder #(.BASE(BASE), .DEPTH(4), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_cond(in_cond), .in_s(in_s), .in_imm(in_imm),
    .in_rd(in_rd), .in_rn(in_rn), .in_rm(in_rm),
    .in_imm12(in_imm12), .in_imm24(in_imm24),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wd(imem_wd),
    .count(count), .full(full), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_fields(input logic [3:0] op, input logic [3:0] cond, input logic s,
                            input logic imm, input logic [3:0] rd, input logic [3:0] rn,
                            input logic [3:0] rm, input logic [11:0] imm12,
                            input logic [23:0] imm24);
    in_op = op; in_cond = cond; in_s = s; in_imm = imm;
    in_rd = rd; in_rn = rn; in_rm = rm; in_imm12 = imm12; in_imm24 = imm24;
  endtask

  // One request from IDLE; captures outputs after T+1 and T+2.
  task automatic send(input logic [3:0] op, input logic [3:0] cond, input logic s,
                      input logic imm, input logic [3:0] rd, input logic [3:0] rn,
                      input logic [3:0] rm, input logic [11:0] imm12,
                      input logic [23:0] imm24);
    set_fields(op, cond, s, imm, rd, rn, rm, imm12, imm24);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    obs_we = imem_we; obs_addr = imem_addr; obs_wd = imem_wd;
    obs_err = err; obs_ready_mid = in_ready;
    @(posedge clk); #1;
    obs_we_after = imem_we; obs_count = count; obs_ready = in_ready;
    $display("txn op=%0d cond=%h we=%0b addr=%h wd=%h count=%0d err=%0b",
             op, cond, obs_we, obs_addr, obs_wd, obs_count, obs_err);
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
    checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", imem_we); end
    checks++; if (imem_addr !== BASE) begin errors++; $display("FAIL reset_addr: got %h expected %h", imem_addr, BASE); end
    checks++; if (imem_wd !== 32'h0) begin errors++; $display("FAIL reset_wd: got %h expected 0", imem_wd); end
    checks++; if ({full, err, busy} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {full, err, busy}); end
  endtask

  task automatic test_dp();
    send(4'd0, 4'hE, 1'b0, 1'b1, 4'd2, 4'd0, 4'd0, 12'd5, 24'd0);
    checks++; if (obs_we !== 1'b1 || obs_wd !== 32'hE2802005) begin errors++; $display("FAIL add_wd: got we=%b %h expected we=1 E2802005", obs_we, obs_wd); end
    checks++; if (obs_addr !== 32'h100) begin errors++; $display("FAIL add_addr: got %h expected 00000100", obs_addr); end
    checks++; if (obs_we_after !== 1'b0 || obs_ready !== 1'b1) begin errors++; $display("FAIL add_strobe_len: got we=%b ready=%b expected we=0 ready=1", obs_we_after, obs_ready); end
    send(4'd1, 4'hE, 1'b1, 1'b0, 4'd3, 4'd1, 4'd2, 12'd0, 24'd0);
    checks++; if (obs_wd !== 32'hE0513002) begin errors++; $display("FAIL sub_wd: got %h expected E0513002", obs_wd); end
    checks++; if (obs_addr !== 32'h104) begin errors++; $display("FAIL sub_addr: got %h expected 00000104", obs_addr); end
    checks++; if (obs_count !== 4'd2) begin errors++; $display("FAIL sub_count: got %0d expected 2", obs_count); end
    pulse_clear();
    send(4'd4, 4'hE, 1'b0, 1'b1, 4'd7, 4'd1, 4'd0, 12'd0, 24'd0);
    checks++; if (obs_wd !== 32'hE3510000) begin errors++; $display("FAIL cmp_wd: got %h expected E3510000", obs_wd); end
    send(4'd5, 4'hE, 1'b0, 1'b0, 4'd9, 4'd1, 4'd2, 12'd0, 24'd0);
    checks++; if (obs_wd !== 32'hE1310002) begin errors++; $display("FAIL teq_wd: got %h expected E1310002", obs_wd); end
    send(4'd6, 4'hE, 1'b0, 1'b0, 4'd5, 4'd3, 4'd6, 12'd3, 24'd0);
    checks++; if (obs_wd !== 32'hE1A05186) begin errors++; $display("FAIL lsl_wd: got %h expected E1A05186", obs_wd); end
    checks++; if (obs_addr !== 32'h108 || obs_count !== 4'd3) begin errors++; $display("FAIL lsl_addr_count: got %h/%0d expected 00000108/3", obs_addr, obs_count); end
  endtask

  task automatic test_mem_branch();
    pulse_clear();
    send(4'd7, 4'hE, 1'b0, 1'b0, 4'd4, 4'd0, 4'd0, 12'd8, 24'd0);
    checks++; if (obs_wd !== 32'hE5904008) begin errors++; $display("FAIL ldr_wd: got %h expected E5904008", obs_wd); end
    send(4'd8, 4'hE, 1'b0, 1'b0, 4'd4, 4'd0, 4'd0, 12'd8, 24'd0);
    checks++; if (obs_wd !== 32'hE5804008) begin errors++; $display("FAIL str_wd: got %h expected E5804008", obs_wd); end
    send(4'd9, 4'hE, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 12'd0, 24'd2);
    checks++; if (obs_wd !== 32'hEA000002) begin errors++; $display("FAIL b_wd: got %h expected EA000002", obs_wd); end
    checks++; if (obs_addr !== 32'h108) begin errors++; $display("FAIL b_addr: got %h expected 00000108", obs_addr); end
  endtask

  task automatic test_illegal();
    pulse_clear();
    send(4'd0, 4'hE, 1'b0, 1'b1, 4'd2, 4'd0, 4'd0, 12'd5, 24'd0);
    send(4'd12, 4'hE, 1'b0, 1'b0, 4'd1, 4'd1, 4'd1, 12'd0, 24'd0);
    checks++; if (obs_we !== 1'b0 || obs_err !== 1'b1) begin errors++; $display("FAIL bad_op: got we=%b err=%b expected we=0 err=1", obs_we, obs_err); end
    checks++; if (obs_ready_mid !== 1'b1) begin errors++; $display("FAIL bad_op_ready: got %b expected 1", obs_ready_mid); end
    checks++; if (obs_count !== 4'd1) begin errors++; $display("FAIL bad_op_count: got %0d expected 1", obs_count); end
    pulse_clear();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL clear_err: got %b expected 0", err); end
    send(4'd0, 4'hE, 1'b0, 1'b1, 4'd2, 4'd0, 4'd0, 12'd5, 24'd0);
    send(4'd0, 4'hF, 1'b0, 1'b1, 4'd2, 4'd0, 4'd0, 12'd5, 24'd0);
    checks++; if (obs_we !== 1'b0 || obs_err !== 1'b1 || obs_count !== 4'd1) begin errors++; $display("FAIL bad_cond: got we=%b err=%b count=%0d expected 0/1/1", obs_we, obs_err, obs_count); end
    send(4'd0, 4'hE, 1'b0, 1'b1, 4'd2, 4'd0, 4'd0, 12'd5, 24'd0);
    checks++; if (obs_we !== 1'b1 || obs_addr !== 32'h104 || obs_wd !== 32'hE2802005) begin errors++; $display("FAIL after_bad: got we=%b %h@%h expected E2802005@00000104", obs_we, obs_wd, obs_addr); end
    checks++; if (obs_err !== 1'b1 || obs_count !== 4'd2) begin errors++; $display("FAIL err_sticky: got err=%b count=%0d expected 1/2", obs_err, obs_count); end
  endtask

  task automatic test_back_to_back();
    int nw = 0;
    pulse_clear();
    set_fields(4'd0, 4'hE, 1'b0, 1'b1, 4'd2, 4'd0, 4'd0, 12'd5, 24'd0);
    in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (imem_we === 1'b1) begin
        $display("txn b2b write addr=%h wd=%h", imem_addr, imem_wd);
        checks++; if (imem_addr !== BASE + 32'(nw * 4) || imem_wd !== 32'hE2802005) begin errors++; $display("FAIL b2b_write%0d: got %h@%h expected E2802005@%h", nw, imem_wd, imem_addr, BASE + 32'(nw * 4)); end
        nw++;
      end
    end
    checks++; if (nw != 4) begin errors++; $display("FAIL b2b_writes: got %0d expected 4", nw); end
    checks++; if (full !== 1'b1 || in_ready !== 1'b0 || count !== 4'd4) begin errors++; $display("FAIL b2b_full: got full=%b ready=%b count=%0d expected 1/0/4", full, in_ready, count); end
    clear = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clear_ready: got %b expected 0", in_ready); end
    @(posedge clk); #1;
    checks++; if (count !== 4'd0 || full !== 1'b0 || err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL clear_state: got count=%0d full=%b err=%b busy=%b expected 0/0/0/0", count, full, err, busy); end
    clear = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL clear_ready_idle: got %b expected 0", in_ready); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clear_no_accept: got busy=%b expected 0", busy); end
    clear = 1'b0;
    in_valid = 1'b0;
    send(4'd0, 4'hE, 1'b0, 1'b1, 4'd2, 4'd0, 4'd0, 12'd5, 24'd0);
    checks++; if (obs_we !== 1'b1 || obs_addr !== BASE) begin errors++; $display("FAIL post_clear_addr: got we=%b %h expected we=1 %h", obs_we, obs_addr, BASE); end
  endtask

  task automatic test_abort_reset();
    pulse_clear();
    send(4'd0, 4'hE, 1'b0, 1'b1, 4'd2, 4'd0, 4'd0, 12'd5, 24'd0);
    set_fields(4'd1, 4'hE, 1'b1, 1'b0, 4'd3, 4'd1, 4'd2, 12'd0, 24'd0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL enc_busy: got %b expected 1", busy); end
    reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL async_reset: got busy=%b count=%0d expected 0/0", busy, count); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (imem_we !== 1'b0 || busy !== 1'b0 || count !== 4'd0 || imem_addr !== BASE) begin errors++; $display("FAIL reset_abort: got we=%b busy=%b count=%0d addr=%h expected 0/0/0/%h", imem_we, busy, count, imem_addr, BASE); end
  endtask

  task automatic test_abort_clear();
    send(4'd0, 4'hE, 1'b0, 1'b1, 4'd2, 4'd0, 4'd0, 12'd5, 24'd0);
    set_fields(4'd1, 4'hE, 1'b1, 1'b0, 4'd3, 4'd1, 4'd2, 12'd0, 24'd0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (imem_we !== 1'b1) begin errors++; $display("FAIL wr_we: got %b expected 1", imem_we); end
    clear = 1'b1;
    #1;
    checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL clear_abort_we: got %b expected 0", imem_we); end
    @(posedge clk); #1;
    clear = 1'b0;
    #1;
    checks++; if (imem_we !== 1'b0 || count !== 4'd0 || busy !== 1'b0) begin errors++; $display("FAIL clear_abort: got we=%b count=%0d busy=%b expected 0/0/0", imem_we, count, busy); end
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0;
    set_fields(4'd0, 4'h0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 12'd0, 24'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    test_reset();
    test_dp();
    test_mem_branch();
    test_illegal();
    test_back_to_back();
    test_abort_reset();
    test_abort_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
